alu_rs_scheduler: RTL and testbench

Reservation-station scheduler that owns the single ALU. It buffers dispatched ALU-class micro-ops and snoops both CDBs (ALU and LSB) to wake up pending operands. Each cycle it selects one ready entry and drives it into a registered issue slot that feeds the ALU's `RS_*` inputs. It sits between the dispatcher/decoder and the ALU, and supports whole-buffer flush on branch mispredict.

---
 rtl/alu_rs_scheduler_pkg.sv | 22 ++
 rtl/alu_rs_scheduler_chk.sv | 20 ++
 rtl/rs_pick_ready.sv | 49 ++++
 rtl/alu_rs_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants for the ALU reservation-station scheduler:
// opcode encoding, ROB tag range and boolean helpers.
package alu_rs_scheduler_pkg;

  localparam int ROB_RANGE = 4;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SLT  = 6'd9;
  localparam logic [5:0] OP_SLTU = 6'd10;

endpackage

// File: rtl/alu_rs_scheduler_chk.sv
// Simulation checker for the reservation station: flags a dispatch request
// that arrives while every entry is busy (the request is dropped).
module alu_rs_scheduler_chk (
  input logic clk,
  input logic rst_n,
  input logic rdy,
  input logic clear,
  input logic disp_valid,
  input logic rs_full
);

  // Dispatch into a full station loses the micro-op.
  always @(posedge clk) begin
    if (rst_n && rdy && !clear) begin
      assert (!(disp_valid && rs_full))
        else $warning("alu_rs_scheduler: dispatch dropped, station full");
    end
  end

endmodule

// File: rtl/rs_pick_ready.sv
// Combinational priority selector. Without RS_AGE_PRIORITY_EN the lowest
// requesting index wins; with it (and AGE_EN set) the largest age wins,
// ties going to the lower index.
module rs_pick_ready #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
`ifdef RS_AGE_PRIORITY_EN
  , parameter bit AGE_EN = 1'b1
`endif
) (
  input  logic [N-1:0]          i_req,
`ifdef RS_AGE_PRIORITY_EN
  input  logic [N-1:0][IW-1:0]  i_age,
`endif
  output logic                  o_found,
  output logic [IW-1:0]         o_idx
);

  logic          w_found;
  logic          w_take;
  logic [IW-1:0] w_idx;
`ifdef RS_AGE_PRIORITY_EN
  logic [IW-1:0] w_best;
`endif

  // Scan requesters from index 0 upward, keeping the best candidate so far.
  always_comb begin
    w_found = 1'b0;
    w_take  = 1'b0;
    w_idx   = '0;
`ifdef RS_AGE_PRIORITY_EN
    w_best  = '0;
`endif
    for (int i = 0; i < N; i++) begin
`ifdef RS_AGE_PRIORITY_EN
      w_take = i_req[i] && (!w_found || (AGE_EN && (i_age[i] > w_best)));
      w_best = w_take ? i_age[i] : w_best;
`else
      w_take = i_req[i] && !w_found;
`endif
      w_idx   = w_take ? IW'(i) : w_idx;
      w_found = w_found | w_take;
    end
  end

  assign o_found = w_found;
  assign o_idx   = w_idx;

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation-station scheduler: buffers dispatched ALU micro-ops,
// snoops the ALU and LSB CDBs for operand wakeup and issues one ready entry
// per cycle into a registered slot feeding the ALU.
// Optional feature macro: RS_AGE_PRIORITY_EN (age-based issue priority).
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = ROB_RANGE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [5:0]       disp_op,
  input  logic [31:0]      disp_Vj,
  input  logic [31:0]      disp_Vk,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic             disp_Qj_busy,
  input  logic             disp_Qk_busy,
  input  logic [ROB_W-1:0] disp_Qj,
  input  logic [ROB_W-1:0] disp_Qk,
  input  logic [ROB_W-1:0] disp_rdTag,
  output logic             rs_full,
  input  logic             alu_cdb_en,
  input  logic [ROB_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_en,
  input  logic [ROB_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_val,
  output logic             RS_valid,
  output logic [5:0]       RS_op,
  output logic [31:0]      RS_Vj,
  output logic [31:0]      RS_Vk,
  output logic [31:0]      RS_imm,
  output logic [31:0]      RS_pc,
  output logic [ROB_W-1:0] RS_rdTag
);

  localparam int IW = $clog2(RS_SIZE);

  // Match a pending tag against both buses; the ALU bus wins a double hit.
  function automatic logic [32:0] snoop(
    input logic [ROB_W-1:0] q,
    input logic ae, input logic [ROB_W-1:0] at, input logic [31:0] av,
    input logic le, input logic [ROB_W-1:0] lt, input logic [31:0] lv);
    snoop = (ae && (at == q)) ? {1'b1, av} :
            (le && (lt == q)) ? {1'b1, lv} : {1'b0, 32'd0};
  endfunction

  logic [RS_SIZE-1:0] r_busy, r_qj_busy, r_qk_busy;
  logic [5:0]         r_op  [RS_SIZE];
  logic [31:0]        r_vj  [RS_SIZE];
  logic [31:0]        r_vk  [RS_SIZE];
  logic [31:0]        r_imm [RS_SIZE];
  logic [31:0]        r_pc  [RS_SIZE];
  logic [ROB_W-1:0]   r_qj  [RS_SIZE];
  logic [ROB_W-1:0]   r_qk  [RS_SIZE];
  logic [ROB_W-1:0]   r_tag [RS_SIZE];
`ifdef RS_AGE_PRIORITY_EN
  logic [RS_SIZE-1:0][IW-1:0] r_age;
`endif

  logic             r_rs_valid;
  logic [5:0]       r_rs_op;
  logic [31:0]      r_rs_vj, r_rs_vk, r_rs_imm, r_rs_pc;
  logic [ROB_W-1:0] r_rs_tag;

  logic [RS_SIZE-1:0] w_ready, w_free;
  logic               w_iss_found, w_free_found, w_disp_ok;
  logic [IW-1:0]      w_iss_idx, w_free_idx;
  logic [32:0]        w_snp_j [RS_SIZE];
  logic [32:0]        w_snp_k [RS_SIZE];
  logic [32:0]        w_disp_j, w_disp_k;

  assign w_ready   = r_busy & ~r_qj_busy & ~r_qk_busy;
  assign w_free    = ~r_busy;
  assign rs_full   = &r_busy;
  assign w_disp_ok = disp_valid & ~rs_full & w_free_found;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_snoop
    assign w_snp_j[g] = snoop(r_qj[g], alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                              lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
    assign w_snp_k[g] = snoop(r_qk[g], alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                              lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
  end

  assign w_disp_j = snoop(disp_Qj, alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                          lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
  assign w_disp_k = snoop(disp_Qk, alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                          lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);

`ifdef RS_AGE_PRIORITY_EN
  rs_pick_ready #(.N(RS_SIZE), .AGE_EN(1'b1)) u_pick_issue (
    .i_req(w_ready), .i_age(r_age), .o_found(w_iss_found), .o_idx(w_iss_idx));
  rs_pick_ready #(.N(RS_SIZE), .AGE_EN(1'b0)) u_pick_free (
    .i_req(w_free), .i_age('0), .o_found(w_free_found), .o_idx(w_free_idx));
`else
  rs_pick_ready #(.N(RS_SIZE)) u_pick_issue (
    .i_req(w_ready), .o_found(w_iss_found), .o_idx(w_iss_idx));
  rs_pick_ready #(.N(RS_SIZE)) u_pick_free (
    .i_req(w_free), .o_found(w_free_found), .o_idx(w_free_idx));
`endif

  alu_rs_scheduler_chk u_chk (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .rs_full(rs_full));

  // Entry array, issue register and ages: flush, then wakeup/issue/dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_qj_busy  <= '0;
      r_qk_busy  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i] <= OP_NOP; r_vj[i] <= 32'd0; r_vk[i] <= 32'd0;
        r_imm[i] <= 32'd0; r_pc[i] <= 32'd0;
        r_qj[i] <= '0; r_qk[i] <= '0; r_tag[i] <= '0;
      end
`ifdef RS_AGE_PRIORITY_EN
      r_age      <= '0;
`endif
      r_rs_valid <= 1'b0;
      r_rs_op    <= OP_NOP;
      r_rs_vj    <= 32'd0;
      r_rs_vk    <= 32'd0;
      r_rs_imm   <= 32'd0;
      r_rs_pc    <= 32'd0;
      r_rs_tag   <= '0;
    end else if (clear) begin
      r_busy     <= '0;
`ifdef RS_AGE_PRIORITY_EN
      r_age      <= '0;
`endif
      r_rs_valid <= 1'b0;
      r_rs_op    <= OP_NOP;
    end else if (rdy) begin
      // Wakeup only touches busy entries that are still waiting.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_busy[i] && w_snp_j[i][32]) begin
          r_vj[i]      <= w_snp_j[i][31:0];
          r_qj_busy[i] <= 1'b0;
        end
        if (r_busy[i] && r_qk_busy[i] && w_snp_k[i][32]) begin
          r_vk[i]      <= w_snp_k[i][31:0];
          r_qk_busy[i] <= 1'b0;
        end
      end
      // Issue: the chosen entry is ready, so its registered operands are final.
      if (w_iss_found) begin
        r_rs_valid        <= 1'b1;
        r_rs_op           <= r_op[w_iss_idx];
        r_rs_vj           <= r_vj[w_iss_idx];
        r_rs_vk           <= r_vk[w_iss_idx];
        r_rs_imm          <= r_imm[w_iss_idx];
        r_rs_pc           <= r_pc[w_iss_idx];
        r_rs_tag          <= r_tag[w_iss_idx];
        r_busy[w_iss_idx] <= 1'b0;
      end else begin
        r_rs_valid        <= 1'b0;
        r_rs_op           <= OP_NOP;
      end
      // Dispatch into a slot free in registered state, with same-cycle bypass.
      if (w_disp_ok) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= disp_op;
        r_imm[w_free_idx]     <= disp_imm;
        r_pc[w_free_idx]      <= disp_pc;
        r_tag[w_free_idx]     <= disp_rdTag;
        r_qj[w_free_idx]      <= disp_Qj;
        r_qk[w_free_idx]      <= disp_Qk;
        r_qj_busy[w_free_idx] <= disp_Qj_busy & ~w_disp_j[32];
        r_qk_busy[w_free_idx] <= disp_Qk_busy & ~w_disp_k[32];
        r_vj[w_free_idx]      <= (disp_Qj_busy && w_disp_j[32]) ? w_disp_j[31:0] : disp_Vj;
        r_vk[w_free_idx]      <= (disp_Qk_busy && w_disp_k[32]) ? w_disp_k[31:0] : disp_Vk;
`ifdef RS_AGE_PRIORITY_EN
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && (r_age[i] != {IW{1'b1}})) begin
            r_age[i] <= r_age[i] + 1'b1;
          end
        end
        r_age[w_free_idx]     <= '0;
`endif
      end
    end
  end

  assign RS_valid = r_rs_valid;
  assign RS_op    = r_rs_op;
  assign RS_Vj    = r_rs_vj;
  assign RS_Vk    = r_rs_vk;
  assign RS_imm   = r_rs_imm;
  assign RS_pc    = r_rs_pc;
  assign RS_rdTag = r_rs_tag;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios followed by
// random traffic, all compared against a slot-array reference model.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  localparam int N = 8;
  localparam int AGE_CAP = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy, clear, disp_valid, disp_Qj_busy, disp_Qk_busy;
  logic [5:0]  disp_op;
  logic [31:0] disp_Vj, disp_Vk, disp_imm, disp_pc;
  logic [3:0]  disp_Qj, disp_Qk, disp_rdTag;
  logic        rs_full;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        RS_valid;
  logic [5:0]  RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_imm, RS_pc;
  logic [3:0]  RS_rdTag;

  alu_rs_scheduler #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_Vj(disp_Vj), .disp_Vk(disp_Vk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_Qj_busy(disp_Qj_busy),
    .disp_Qk_busy(disp_Qk_busy), .disp_Qj(disp_Qj), .disp_Qk(disp_Qk),
    .disp_rdTag(disp_rdTag), .rs_full(rs_full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_imm(RS_imm), .RS_pc(RS_pc), .RS_rdTag(RS_rdTag));

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    bit          qjb, qkb;
    logic [3:0]  qj, qk, tag;
    int          stamp;
  } ent_t;

  ent_t        m [N];
  bit          m_valid;
  logic [5:0]  m_op;
  logic [31:0] m_vj, m_vk, m_imm, m_pc;
  logic [3:0]  m_tag;
  int          dcount;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Value broadcast this cycle for tag q (ALU bus has precedence).
  function automatic logic [32:0] bus(input logic [3:0] q);
    if (alu_cdb_en && alu_cdb_tag == q) return {1'b1, alu_cdb_val};
    if (lsb_cdb_en && lsb_cdb_tag == q) return {1'b1, lsb_cdb_val};
    return 33'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '{default: 0};
    m_valid = 0; m_op = OP_NOP; m_vj = 0; m_vk = 0; m_imm = 0; m_pc = 0; m_tag = 0;
    dcount = 0;
  endtask

  // Next state of the model from its current state and the driven inputs.
  task automatic model_step();
    ent_t old [N];
    int sel, best, age, fr;
    logic [32:0] b;
    old = m;
    if (clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_valid = 0; m_op = OP_NOP;
    end else if (rdy) begin
      sel = -1; best = -1;
      for (int i = 0; i < N; i++) begin
        if (old[i].busy && !old[i].qjb && !old[i].qkb) begin
`ifdef RS_AGE_PRIORITY_EN
          age = dcount - old[i].stamp;
          if (age > AGE_CAP) age = AGE_CAP;
`else
          age = 0;
`endif
          if (sel < 0 || age > best) begin sel = i; best = age; end
        end
      end
      if (sel >= 0) begin
        m_valid = 1; m_op = old[sel].op; m_vj = old[sel].vj; m_vk = old[sel].vk;
        m_imm = old[sel].imm; m_pc = old[sel].pc; m_tag = old[sel].tag;
        m[sel].busy = 0;
      end else begin
        m_valid = 0; m_op = OP_NOP;
      end
      for (int i = 0; i < N; i++) begin
        if (old[i].busy && old[i].qjb) begin
          b = bus(old[i].qj);
          if (b[32]) begin m[i].vj = b[31:0]; m[i].qjb = 0; end
        end
        if (old[i].busy && old[i].qkb) begin
          b = bus(old[i].qk);
          if (b[32]) begin m[i].vk = b[31:0]; m[i].qkb = 0; end
        end
      end
      fr = -1;
      for (int i = N - 1; i >= 0; i--) if (!old[i].busy) fr = i;
      if (disp_valid && fr >= 0) begin
        m[fr].busy = 1; m[fr].op = disp_op; m[fr].imm = disp_imm; m[fr].pc = disp_pc;
        m[fr].tag = disp_rdTag; m[fr].qj = disp_Qj; m[fr].qk = disp_Qk;
        m[fr].vj = disp_Vj; m[fr].qjb = disp_Qj_busy;
        m[fr].vk = disp_Vk; m[fr].qkb = disp_Qk_busy;
        b = bus(disp_Qj);
        if (disp_Qj_busy && b[32]) begin m[fr].vj = b[31:0]; m[fr].qjb = 0; end
        b = bus(disp_Qk);
        if (disp_Qk_busy && b[32]) begin m[fr].vk = b[31:0]; m[fr].qkb = 0; end
        m[fr].stamp = dcount;
        dcount++;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(RS_valid), 32'(m_valid));
    chk("op", 32'(RS_op), 32'(m_op));
    chk("vj", RS_Vj, m_vj);
    chk("vk", RS_Vk, m_vk);
    chk("imm", RS_imm, m_imm);
    chk("pc", RS_pc, m_pc);
    chk("rdtag", 32'(RS_rdTag), 32'(m_tag));
    chk("rs_full", 32'(rs_full), 32'(model_full()));
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle();
    rdy = 1; clear = 0; disp_valid = 0; alu_cdb_en = 0; lsb_cdb_en = 0;
    disp_Qj_busy = 0; disp_Qk_busy = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input bit qjb, input logic [3:0] qj, input bit qkb,
                      input logic [3:0] qk, input logic [3:0] tag);
    disp_valid = 1; disp_op = op; disp_Vj = vj; disp_Vk = vk;
    disp_Qj_busy = qjb; disp_Qj = qj; disp_Qk_busy = qkb; disp_Qk = qk;
    disp_rdTag = tag; disp_imm = 32'h100 + 32'(tag); disp_pc = 32'h4000 + 32'(tag) * 4;
  endtask

  int issues;

  initial begin
    rst_n = 0; idle();
    disp_op = 0; disp_Vj = 0; disp_Vk = 0; disp_imm = 0; disp_pc = 0;
    disp_Qj = 0; disp_Qk = 0; disp_rdTag = 0;
    alu_cdb_tag = 0; alu_cdb_val = 0; lsb_cdb_tag = 0; lsb_cdb_val = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // ADD 5+7, both ready, tag 3: in the issue register two edges later.
    disp(OP_ADD, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 4'd3); step();
    idle(); step();
    chk("add_valid", 32'(RS_valid), 32'd1);
    chk("add_op", 32'(RS_op), 32'(OP_ADD));
    chk("add_tag", 32'(RS_rdTag), 32'd3);
    chk("add_alu", RS_Vj + RS_Vk, 32'd12);

    // SUB waiting on tag 2, woken by the LSB bus with 100.
    disp(OP_SUB, 32'd0, 32'd1, 1, 4'd2, 0, 4'd0, 4'd4); step();
    idle(); lsb_cdb_en = 1; lsb_cdb_tag = 4'd2; lsb_cdb_val = 32'd100; step();
    chk("sub_not_yet", 32'(RS_valid), 32'd0);
    idle(); step();
    chk("sub_vj", RS_Vj, 32'd100);
    chk("sub_alu", RS_Vj - RS_Vk, 32'd99);

    // Same-cycle dispatch bypass from the ALU bus.
    disp(OP_ADD, 32'd1, 32'd0, 0, 4'd0, 1, 4'd6, 4'd5);
    alu_cdb_en = 1; alu_cdb_tag = 4'd6; alu_cdb_val = 32'h55; step();
    idle(); step();
    chk("byp_valid", 32'(RS_valid), 32'd1);
    chk("byp_vk", RS_Vk, 32'h55);

    // Fill all entries with ops waiting on tag 9, then a dropped 9th.
    for (int i = 0; i < N; i++) begin
      disp(OP_ADD, 32'd0, 32'(i), 1, 4'd9, 0, 4'd0, 4'(i)); step();
    end
    chk("full_after_fill", 32'(rs_full), 32'd1);
    disp(OP_SUB, 32'd0, 32'd0, 0, 4'd0, 0, 4'd0, 4'd15); step();
    chk("full_after_drop", 32'(rs_full), 32'd1);
    idle(); alu_cdb_en = 1; alu_cdb_tag = 4'd9; alu_cdb_val = 32'hA5; step();
    idle();
    for (int i = 0; i < N; i++) begin
      step();
      chk("order_valid", 32'(RS_valid), 32'd1);
      chk("order_tag", 32'(RS_rdTag), 32'(i));
    end
    step();
    chk("drained", 32'(RS_valid), 32'd0);

    // Flush three pending entries; their later wakeup must not issue.
    for (int i = 1; i <= 3; i++) begin
      disp(OP_OR, 32'd0, 32'd0, 1, 4'd10, 0, 4'd0, 4'(i)); step();
    end
    idle(); clear = 1; step();
    chk("clr_valid", 32'(RS_valid), 32'd0);
    chk("clr_full", 32'(rs_full), 32'd0);
    idle(); alu_cdb_en = 1; alu_cdb_tag = 4'd10; alu_cdb_val = 32'd1; step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_no_issue", 32'(RS_valid), 32'd0);
    end

    // Freeze with a ready entry, then exactly one issue after release.
    disp(OP_ADD, 32'd3, 32'd4, 0, 4'd0, 0, 4'd0, 4'd7); step();
    for (int i = 0; i < 4; i++) begin
      idle(); rdy = 0;
      disp(OP_XOR, 32'(i), 32'd0, 0, 4'd0, 0, 4'd0, 4'd12);
      alu_cdb_en = 1; alu_cdb_tag = 4'(i); alu_cdb_val = 32'hDEAD;
      step();
      chk("frz_valid", 32'(RS_valid), 32'd0);
    end
    idle(); issues = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (RS_valid && RS_rdTag == 4'd7) issues++;
    end
    chk("rdy_one_issue", 32'(issues), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(7) != 0);
      clear = ($urandom_range(39) == 0);
      disp_valid = ($urandom_range(1) == 1) && !model_full();
      disp_op = 6'($urandom_range(10)); disp_Vj = $urandom; disp_Vk = $urandom;
      disp_imm = $urandom; disp_pc = $urandom;
      disp_Qj_busy = $urandom_range(1); disp_Qk_busy = $urandom_range(1);
      disp_Qj = 4'($urandom_range(7)); disp_Qk = 4'($urandom_range(7));
      disp_rdTag = 4'($urandom);
      alu_cdb_en = $urandom_range(1); alu_cdb_tag = 4'($urandom_range(7)); alu_cdb_val = $urandom;
      lsb_cdb_en = $urandom_range(1); lsb_cdb_tag = 4'($urandom_range(7)); lsb_cdb_val = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
